// File: rtl/l15_req_buffer.sv
// l15_req_buffer: request FIFO towards the L1.5 with a two-state issue FSM
// and an outstanding-request counter that throttles issue at MAX_OUTST.
module l15_req_buffer #(
  parameter int DEPTH     = 2,
  parameter int MAX_OUTST = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_val_i,
  output logic        req_rdy_o,
  input  logic [4:0]  req_rqtype_i,
  input  logic [2:0]  req_size_i,
  input  logic [39:0] req_address_i,
  input  logic [63:0] req_data_i,
  output logic        l15_val_o,
  output logic [4:0]  l15_rqtype_o,
  output logic [2:0]  l15_size_o,
  output logic [39:0] l15_address_o,
  output logic [63:0] l15_data_o,
  input  logic        l15_header_ack_i,
  input  logic        l15_rtrn_val_i,
  input  logic [3:0]  l15_rtrn_rqtype_i,
  output logic [3:0]  outst_cnt_o,
  output logic        idle_o,
  output logic        err_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;
  localparam logic [3:0] MAX   = 4'(MAX_OUTST);
  logic [0:0]   state, state_n;
  logic [PW:0]  wr_ptr, rd_ptr, occ, occ_n;
  logic [111:0] mem [DEPTH];
  logic [3:0]   cnt, cnt_n;
  logic         push, pop, ret, full, err;
  // occupancy never exceeds DEPTH = 2**PW, so its top bit alone flags full
  assign occ       = wr_ptr - rd_ptr;
  assign full      = occ[PW];
  assign req_rdy_o = !full;
  assign push      = req_val_i && !full;
  assign pop       = state == ISSUE && l15_header_ack_i;
  assign ret       = l15_rtrn_val_i && l15_rtrn_rqtype_i != 4'b0111;
  always_comb begin
    occ_n   = occ + (PW+1)'(push) - (PW+1)'(pop);
    cnt_n   = (pop && !ret) ? cnt + 4'd1 : (ret && !pop && cnt != 4'd0) ? cnt - 4'd1 : cnt;
    state_n = (state == IDLE || pop) ? ((occ_n != '0 && cnt_n < MAX) ? ISSUE : IDLE) : state;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      wr_ptr <= wr_ptr + (PW+1)'(push);
      rd_ptr <= rd_ptr + (PW+1)'(pop);
      cnt    <= cnt_n;
      if (ret && !pop && cnt == 4'd0) err <= 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[PW-1:0]] <= {req_rqtype_i, req_size_i, req_address_i, req_data_i};
  end
  assign l15_val_o = state == ISSUE;
  assign {l15_rqtype_o, l15_size_o, l15_address_o, l15_data_o} = l15_val_o ? mem[rd_ptr[PW-1:0]] : '0;
  assign outst_cnt_o = cnt;
  assign idle_o      = occ == '0 && cnt == 4'd0;
  assign err_o       = err;
endmodule

// File: tb/tb_l15_req_buffer.sv
// tb_l15_req_buffer: scoreboard bench; requests are queued when accepted and
// compared against the head presented to the L1.5 on every header ack.
module tb_l15_req_buffer;
  typedef struct packed {
    logic [4:0]  t;
    logic [2:0]  s;
    logic [39:0] a;
    logic [63:0] d;
  } req_t;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_val_i = 1'b0;
  logic        req_rdy_o;
  logic [4:0]  req_rqtype_i = '0;
  logic [2:0]  req_size_i = '0;
  logic [39:0] req_address_i = '0;
  logic [63:0] req_data_i = '0;
  logic        l15_val_o;
  logic [4:0]  l15_rqtype_o;
  logic [2:0]  l15_size_o;
  logic [39:0] l15_address_o;
  logic [63:0] l15_data_o;
  logic        l15_header_ack_i = 1'b0;
  logic        l15_rtrn_val_i = 1'b0;
  logic [3:0]  l15_rtrn_rqtype_i = '0;
  logic [3:0]  outst_cnt_o;
  logic        idle_o;
  logic        err_o;
  int          checks = 0;
  int          errors = 0;
  req_t        q[$];
  req_t        r1, r2, r3;
  int          waited;

  l15_req_buffer #(.DEPTH(2), .MAX_OUTST(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_val_i(req_val_i), .req_rdy_o(req_rdy_o),
    .req_rqtype_i(req_rqtype_i), .req_size_i(req_size_i),
    .req_address_i(req_address_i), .req_data_i(req_data_i),
    .l15_val_o(l15_val_o), .l15_rqtype_o(l15_rqtype_o), .l15_size_o(l15_size_o),
    .l15_address_o(l15_address_o), .l15_data_o(l15_data_o),
    .l15_header_ack_i(l15_header_ack_i),
    .l15_rtrn_val_i(l15_rtrn_val_i), .l15_rtrn_rqtype_i(l15_rtrn_rqtype_i),
    .outst_cnt_o(outst_cnt_o), .idle_o(idle_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic req_t mk(input int n);
    req_t r;
    r.t = 5'(n);
    r.s = 3'(n + 1);
    r.a = 40'h80_0000_0000 + 40'(n * 64);
    r.d = {32'hcafe_0000 + 32'(n), 32'h1234_5600 + 32'(n)};
    return r;
  endfunction

  task automatic drive(input req_t r);
    req_val_i     = 1'b1;
    req_rqtype_i  = r.t;
    req_size_i    = r.s;
    req_address_i = r.a;
    req_data_i    = r.d;
  endtask

  // holds the request until accepted; returns the number of edges it took
  task automatic send(input req_t r, output int n);
    logic acc;
    n = 0;
    drive(r);
    do begin
      @(negedge clk_i);
      acc = req_rdy_o;
      step();
      n++;
    end while (!acc && n < 20);
    if (acc) q.push_back(r);
    else chk("send_timeout", 0, 1);
    req_val_i = 1'b0;
  endtask

  task automatic rtrn(input logic [3:0] t, input int n);
    l15_rtrn_val_i    = 1'b1;
    l15_rtrn_rqtype_i = t;
    repeat (n) step();
    l15_rtrn_val_i = 1'b0;
  endtask

  always @(negedge clk_i) begin
    if (l15_val_o && l15_header_ack_i) begin
      if (q.size() == 0) chk("issue_unexpected", 1, 0);
      else chk("issue", {l15_rqtype_o, l15_size_o, l15_address_o, l15_data_o}, q.pop_front());
    end
  end

  initial begin
    #3;
    chk("rst_val", l15_val_o, 0);
    chk("rst_rdy", req_rdy_o, 1);
    chk("rst_idle", idle_o, 1);
    chk("rst_cnt", outst_cnt_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_addr", l15_address_o, 0);
    step();
    step();
    rst_ni = 1'b1;

    // single load, held until ack, then returned
    r1 = mk(0);
    r1.a = 40'h80_0000_1000;
    send(r1, waited);
    chk("load_val1", l15_val_o, 1);
    chk("load_addr", l15_address_o, 40'h80_0000_1000);
    step();
    chk("load_val2", l15_val_o, 1);
    step();
    chk("load_val3", l15_val_o, 1);
    chk("load_data", l15_data_o, r1.d);
    l15_header_ack_i = 1'b1;
    step();
    l15_header_ack_i = 1'b0;
    chk("load_val_drop", l15_val_o, 0);
    chk("load_cnt1", outst_cnt_o, 1);
    chk("load_idle0", idle_o, 0);
    chk("load_zero_fields", {l15_rqtype_o, l15_size_o, l15_data_o}, 0);
    rtrn(4'd0, 1);
    chk("load_cnt0", outst_cnt_o, 0);
    chk("load_idle1", idle_o, 1);

    // backpressure with DEPTH=2
    r1 = mk(1);
    r2 = mk(2);
    r3 = mk(3);
    drive(r1);
    chk("bp_rdy1", req_rdy_o, 1);
    step();
    q.push_back(r1);
    drive(r2);
    chk("bp_rdy2", req_rdy_o, 1);
    step();
    q.push_back(r2);
    drive(r3);
    chk("bp_rdy_full", req_rdy_o, 0);
    step();
    chk("bp_rdy_hold", req_rdy_o, 0);
    chk("bp_head", l15_address_o, r1.a);
    chk("bp_cnt0", outst_cnt_o, 0);
    l15_header_ack_i = 1'b1;
    step();
    chk("bp_rdy_free", req_rdy_o, 1);
    chk("bp_cnt1", outst_cnt_o, 1);
    chk("bp_b2b_val", l15_val_o, 1);
    step();
    q.push_back(r3);
    req_val_i = 1'b0;
    step();
    l15_header_ack_i = 1'b0;
    chk("bp_val_end", l15_val_o, 0);
    chk("bp_cnt3", outst_cnt_o, 3);

    // INT_RET does not count; ack plus counted return leaves the count
    rtrn(4'b0111, 1);
    chk("intret_cnt", outst_cnt_o, 3);
    rtrn(4'd0, 1);
    chk("ret_cnt2", outst_cnt_o, 2);
    send(mk(4), waited);
    chk("sim_val", l15_val_o, 1);
    l15_header_ack_i = 1'b1;
    l15_rtrn_val_i = 1'b1;
    l15_rtrn_rqtype_i = 4'd0;
    step();
    l15_header_ack_i = 1'b0;
    l15_rtrn_val_i = 1'b0;
    chk("sim_cnt", outst_cnt_o, 2);
    rtrn(4'd0, 2);
    chk("sim_drain", idle_o, 1);

    // outstanding limit: 5 requests, ack always high
    l15_header_ack_i = 1'b1;
    for (int i = 0; i < 5; i++) send(mk(10 + i), waited);
    chk("lim_val", l15_val_o, 0);
    chk("lim_cnt", outst_cnt_o, 4);
    chk("lim_fields", l15_address_o, 0);
    step();
    step();
    chk("lim_ack_ignored", outst_cnt_o, 4);
    chk("lim_val_hold", l15_val_o, 0);
    rtrn(4'd0, 1);
    chk("lim_5th_val", l15_val_o, 1);
    chk("lim_5th_addr", l15_address_o, mk(14).a);
    step();
    l15_header_ack_i = 1'b0;
    chk("lim_cnt_after", outst_cnt_o, 4);
    rtrn(4'd0, 4);
    chk("lim_drain", idle_o, 1);
    chk("err_clean", err_o, 0);

    // underflow
    rtrn(4'd0, 1);
    chk("uf_err", err_o, 1);
    chk("uf_cnt", outst_cnt_o, 0);
    step();
    step();
    chk("uf_sticky", err_o, 1);

    // asynchronous reset while issuing
    send(mk(20), waited);
    chk("ar_val_before", l15_val_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("ar_val", l15_val_o, 0);
    chk("ar_rdy", req_rdy_o, 1);
    chk("ar_idle", idle_o, 1);
    chk("ar_cnt", outst_cnt_o, 0);
    chk("ar_err", err_o, 0);
    chk("ar_addr", l15_address_o, 0);
    q.delete();
    step();
    rst_ni = 1'b1;
    send(mk(21), waited);
    chk("ar_first_accept", waited, 1);
    chk("ar_val_new", l15_val_o, 1);
    l15_header_ack_i = 1'b1;
    step();
    l15_header_ack_i = 1'b0;
    rtrn(4'd0, 1);
    chk("ar_drain", idle_o, 1);
    chk("sb_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/l15_req_buffer.md
L15_REQ_BUFFER -- requirements
Module: l15_req_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2: request FIFO entries, power of two, at least 2.
REQ-002 SHALL have parameter MAX_OUTST, default 4: maximum requests issued and not yet returned, range 1-15.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port req_val_i, input, 1: core request valid.
REQ-006 SHALL have port req_rdy_o, output, 1: buffer can accept a request.
REQ-007 SHALL have port req_rqtype_i, input, 5: L1.5 request type.
REQ-008 SHALL have port req_size_i, input, 3: access size.
REQ-009 SHALL have port req_address_i, input, 40: physical address.
REQ-010 SHALL have port req_data_i, input, 64: store data.
REQ-011 SHALL have port l15_val_o, output, 1: request valid towards L1.5.
REQ-012 SHALL have ports l15_rqtype_o (5), l15_size_o (3), l15_address_o (40) and l15_data_o (64), all outputs: the head-entry fields.
REQ-013 SHALL have port l15_header_ack_i, input, 1: L1.5 has accepted the presented request.
REQ-014 SHALL have port l15_rtrn_val_i, input, 1: an L1.5 return packet is valid this cycle.
REQ-015 SHALL have port l15_rtrn_rqtype_i, input, 4: return type; 4'b0111 (INT_RET) is unsolicited.
REQ-016 SHALL have port outst_cnt_o, output, 4: current outstanding count.
REQ-017 SHALL have port idle_o, output, 1: FIFO is empty and the outstanding count is 0.
REQ-018 SHALL have port err_o, output, 1: sticky flag for an unmatched return.

Function
REQ-019 SHALL drive req_rdy_o = (FIFO occupancy < DEPTH), registered-state based, with no combinational path from l15_header_ack_i.
REQ-020 SHALL enqueue the four request fields when req_val_i & req_rdy_o, in arrival order.
REQ-021 SHALL use a two-state FSM: IDLE (l15_val_o=0) and ISSUE (l15_val_o=1).
REQ-022 SHALL move IDLE->ISSUE on the clock edge where the FIFO is non-empty and outst_cnt < MAX_OUTST.
REQ-023 SHALL hold l15_val_o and all l15_* fields stable in ISSUE until l15_header_ack_i is sampled 1.
REQ-024 SHALL, on l15_header_ack_i in ISSUE: pop the head and increment the outstanding count.
REQ-025 SHALL, in that same ack cycle, stay in ISSUE (next head presented the following cycle, giving back-to-back issue) if after the pop the FIFO is non-empty and the count is below MAX_OUTST; otherwise SHALL go to IDLE.
REQ-026 SHALL ignore l15_header_ack_i while in IDLE.
REQ-027 SHALL decrement the outstanding count on l15_rtrn_val_i & (l15_rtrn_rqtype_i != 4'b0111); INT_RET returns SHALL NOT change the count.
REQ-028 SHALL leave the count unchanged when a pop and a counted return occur in the same cycle.
REQ-029 SHALL, on a counted return while the count is 0: hold the count at 0 and set err_o=1 until reset.
REQ-030 SHALL accept an enqueue into a FIFO holding DEPTH-1 entries in the same cycle as a pop, with no loss and no duplication.
REQ-031 SHALL wrap FIFO read/write pointers modulo DEPTH, with an extra wrap bit to tell full from empty.
REQ-032 SHALL give a latency of 1 cycle from enqueue into an empty FIFO (in IDLE, count below limit) to l15_val_o=1.
REQ-033 SHALL drive l15_* data fields to 0 whenever l15_val_o=0.

Reset
REQ-034 SHALL, while rst_ni=0 (asynchronously): FSM=IDLE, FIFO empty, count=0, err_o=0, l15_val_o=0, req_rdy_o=1, idle_o=1, outst_cnt_o=0, l15_* fields=0.
REQ-035 SHALL, on reset asserted mid-ISSUE, drop l15_val_o to 0 immediately and discard all FIFO contents and the outstanding count.
REQ-036 SHALL accept a request in the first cycle after rst_ni deasserts.

Verification
REQ-037 SHALL cover single load: enqueue rqtype=0, addr=40'h80_0000_1000 -> l15_val_o=1 next cycle, held 3 cycles until ack; outst_cnt_o=1; a return of type 0 gives outst_cnt_o=0 and idle_o=1.
REQ-038 SHALL cover backpressure: DEPTH=2, 3 back-to-back requests with no ack -> req_rdy_o=0 after the 2nd enqueue, the 3rd is held by the core, and order is preserved on acks.
REQ-039 SHALL cover the limit: MAX_OUTST=4, 5 requests acked immediately with no returns -> 4 issued, l15_val_o=0 while count=4; one return -> the 5th issues next cycle.
REQ-040 SHALL cover simultaneous events: count=2, ack and counted return in the same cycle -> count stays 2; an INT_RET return -> count unchanged.
REQ-041 SHALL cover underflow: count=0, return of type 0 -> err_o=1 and count=0; err_o stays 1 until rst_ni=0.
REQ-042 SHALL cover reset mid-ISSUE: rst_ni=0 asynchronously while l15_val_o=1 -> l15_val_o=0 before the next clock edge and all REQ-034 values hold.
